cache_stats_dump_sequencer: RTL

//  Sequences readout of the cache performance/statistics block for the host.
//  - On start: freezes counting, selects a data record, walks a word-index window, captures each returned word.
//  - Streams captured words out on a valid/ready port, then restores counting.
//  - Sits between the host comm bus and the L2 performance controller; sole driver of its comm/select inputs.

---
 rtl/cache_stats_dump_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_stats_dump_sequencer.sv
// Cache statistics dump sequencer.
// Freezes the L2 performance counters, walks a word-index window of the
// selected data record, captures each returned word and streams it out on a
// valid/ready port. Counting is restored once the dump ends.
// Optional feature macro: STATS_DUMP_CHECKSUM_EN appends one XOR checksum
// word after the data words and moves data_last_o onto it.
module cache_stats_dump_sequencer #(
  parameter int unsigned READ_LATENCY = 2,
  parameter bit          FREEZE_EN    = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        count_enable_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [1:0]  record_sel_i,
  input  logic [5:0]  base_index_i,
  input  logic [6:0]  count_i,
  output logic [31:0] comm_o,
  output logic [1:0]  select_data_record_o,
  input  logic [31:0] comm_i,
  output logic [31:0] data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        data_last_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_OUTPUT,
    ST_DONE
`ifdef STATS_DUMP_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_t;

`ifdef STATS_DUMP_CHECKSUM_EN
  localparam state_t TAIL_STATE = ST_CSUM;
`else
  localparam state_t TAIL_STATE = ST_DONE;
`endif

  localparam logic [2:0] LATENCY_LOAD = 3'(READ_LATENCY);

  state_t state, state_next;

  logic [5:0]  idx_q, idx_n;
  logic [6:0]  rem_q, rem_n;
  logic [2:0]  wait_q, wait_n;
  logic [1:0]  sel_n;
  logic [31:0] data_n;
  logic        valid_n, last_n, busy_n, done_n;
  logic [31:0] comm_n;
`ifdef STATS_DUMP_CHECKSUM_EN
  logic [31:0] csum_q, csum_n;
`endif

  logic abort_hit, start_hit, final_word;

  // The index register lives in comm_o itself; no separate copy is kept.
  assign idx_q      = comm_o[5:0];
  assign abort_hit  = abort_i && (state != ST_IDLE);
  assign start_hit  = start_i && !abort_i && (state == ST_IDLE);
  assign final_word = (rem_q == 7'd1);

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_hit) state_next = (count_i == '0) ? TAIL_STATE : ST_SETUP;
      ST_SETUP:  state_next = ST_WAIT;
      ST_WAIT:   if (wait_q == '0) state_next = ST_OUTPUT;
      ST_OUTPUT: if (data_ready_i) state_next = final_word ? TAIL_STATE : ST_WAIT;
`ifdef STATS_DUMP_CHECKSUM_EN
      ST_CSUM:   if (data_ready_i) state_next = ST_DONE;
`endif
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (abort_hit) state_next = ST_IDLE;
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    sel_n   = select_data_record_o;
    idx_n   = idx_q;
    rem_n   = rem_q;
    wait_n  = wait_q;
    data_n  = data_o;
    valid_n = data_valid_o;
    last_n  = data_last_o;
`ifdef STATS_DUMP_CHECKSUM_EN
    csum_n  = csum_q;
`endif
    case (state)
      ST_IDLE: begin
        if (start_hit) begin
          sel_n = record_sel_i;
          idx_n = base_index_i;
          rem_n = count_i;
`ifdef STATS_DUMP_CHECKSUM_EN
          csum_n = '0;
          if (count_i == '0) begin
            data_n  = '0;
            valid_n = 1'b1;
            last_n  = 1'b1;
          end
`endif
        end
      end
      ST_SETUP: wait_n = LATENCY_LOAD;
      ST_WAIT: begin
        if (wait_q == '0) begin
          data_n  = comm_i;
          valid_n = 1'b1;
`ifdef STATS_DUMP_CHECKSUM_EN
          last_n  = 1'b0;
          csum_n  = csum_q ^ comm_i;
`else
          last_n  = final_word;
`endif
        end else begin
          wait_n = wait_q - 3'd1;
        end
      end
      ST_OUTPUT: begin
        if (data_ready_i) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          rem_n   = rem_q - 7'd1;
          if (!final_word) begin
            idx_n  = idx_q + 6'd1;
            wait_n = LATENCY_LOAD;
          end
`ifdef STATS_DUMP_CHECKSUM_EN
          else begin
            data_n  = csum_q;
            valid_n = 1'b1;
            last_n  = 1'b1;
          end
`endif
        end
      end
`ifdef STATS_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (data_ready_i) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
        end
      end
`endif
      default: ;
    endcase
    if (abort_hit) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
    end
    // Select and index fall back to their idle value whenever the dump ends.
    if (state_next == ST_IDLE || state_next == ST_DONE) begin
      sel_n = '0;
      idx_n = '0;
    end
    busy_n     = (state_next != ST_IDLE);
    done_n     = (state_next == ST_DONE);
    comm_n     = '0;
    comm_n[24] = count_enable_i & ~(FREEZE_EN & busy_n);
    comm_n[5:0] = idx_n;
  end

  // Output and datapath registers, all loaded from the next-value decode.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      comm_o               <= '0;
      select_data_record_o <= '0;
      data_o               <= '0;
      data_valid_o         <= 1'b0;
      data_last_o          <= 1'b0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
      rem_q                <= '0;
      wait_q               <= '0;
`ifdef STATS_DUMP_CHECKSUM_EN
      csum_q               <= '0;
`endif
    end else begin
      comm_o               <= comm_n;
      select_data_record_o <= sel_n;
      data_o               <= data_n;
      data_valid_o         <= valid_n;
      data_last_o          <= last_n;
      busy_o               <= busy_n;
      done_o               <= done_n;
      rem_q                <= rem_n;
      wait_q               <= wait_n;
`ifdef STATS_DUMP_CHECKSUM_EN
      csum_q               <= csum_n;
`endif
    end
  end

endmodule
